// File: rtl/pbit_sample_decoder.sv
// Samples one stochastic p-bit bus per cycle over a programmable window and
// majority-decodes the per-bit ones counts into a deterministic result word.

module pbit_cnt_lane #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  input  logic [CNT_W-1:0] win_i,
  output logic [CNT_W-1:0] nxt_o,
  output logic             maj_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign nxt_o = cnt_q + CNT_W'(bit_i);
  // One extra bit so 2*count never wraps; a tie decodes to 0.
  assign maj_o = {nxt_o, 1'b0} > {1'b0, win_i};

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = nxt_o;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

module pbit_sample_decoder #(
  parameter int WIDTH      = 4,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             sel,
  input  logic [CNT_W-1:0]       window,
  input  logic [WIDTH-1:0]       a_out,
  input  logic [WIDTH-1:0]       b_out,
  input  logic [WIDTH-1:0]       sum_out,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       result,
  output logic [WIDTH*CNT_W-1:0] ones_cnt
);
  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM} state_e;

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SET_LAST = SW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  state_e                        state_q, state_d;
  logic [1:0]                    sel_q, sel_d;
  logic [CNT_W-1:0]              win_q, win_d;
  logic [CNT_W-1:0]              samp_q, samp_d, samp_nxt;
  logic [SW-1:0]                 set_q, set_d;
  logic                          done_q, done_d;
  logic [WIDTH-1:0]              res_q, res_d;
  logic [WIDTH-1:0][CNT_W-1:0]   ones_q, ones_d;

  logic [WIDTH-1:0]              bus;
  logic [WIDTH-1:0][CNT_W-1:0]   lane_nxt;
  logic [WIDTH-1:0]              lane_maj;
  logic                          accept, last, lane_en;

  always_comb begin
    case (sel_q)
      2'd1:    bus = a_out;
      2'd2:    bus = b_out;
      default: bus = sum_out;
    endcase
  end

  assign accept   = (state_q == IDLE) && start && (window != '0);
  assign samp_nxt = samp_q + CNT_W'(1);
  assign last     = (samp_nxt == win_q);
  assign lane_en  = (state_q == ACCUM) && !abort;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    pbit_cnt_lane #(.CNT_W(CNT_W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr_i (accept),
      .en_i  (lane_en),
      .bit_i (bus[i]),
      .win_i (win_q),
      .nxt_o (lane_nxt[i]),
      .maj_o (lane_maj[i])
    );
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    win_d   = win_q;
    samp_d  = samp_q;
    set_d   = set_q;
    done_d  = 1'b0;
    res_d   = res_q;
    ones_d  = ones_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d   = sel;
          win_d   = window;
          samp_d  = '0;
          set_d   = '0;
          state_d = (SETTLE_CYC == 0) ? ACCUM : SETTLE;
        end
      end
      SETTLE: begin
        if (abort)                 state_d = IDLE;
        else if (set_q == SET_LAST) state_d = ACCUM;
        else                       set_d   = set_q + SW'(1);
      end
      ACCUM: begin
        // Abort wins over completion: no done, outputs keep the old run.
        if (abort) begin
          state_d = IDLE;
        end else begin
          samp_d = samp_nxt;
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
            res_d   = lane_maj;
            ones_d  = lane_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      win_q   <= '0;
      samp_q  <= '0;
      set_q   <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      win_q   <= win_d;
      samp_q  <= samp_d;
      set_q   <= set_d;
      done_q  <= done_d;
      res_q   <= res_d;
      ones_q  <= ones_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign result   = res_q;
  assign ones_cnt = ones_q;
endmodule

// File: doc/pbit_sample_decoder.md
# pbit_sample_decoder

Downstream consumer of the 4-bit invertible p-bit ripple adder. Each cycle it samples one of the adder's stochastic output buses (a, b or sum), counts the 1-samples of every bit over a programmable window after an optional settle period, and majority-decodes the counts into a deterministic result word. The on-chip hardware replaces the bench-side bit averaging and produces a done-pulsed result plus raw per-bit counts.

## Interface
- WIDTH, 4, number of adder bits sampled
- CNT_W, 16, width of the window length and of each per-bit ones counter
- SETTLE_CYC, 2, cycles discarded after start before counting begins; 0 means no settle phase
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- start  input  1  request a measurement; honoured only in IDLE with window != 0
- abort  input  1  cancel an in-progress measurement
- sel  input  2  bus select: 0 = sum_out, 1 = a_out, 2 = b_out, 3 = sum_out
- window  input  CNT_W  number of samples to count
- a_out  input  WIDTH  adder p-bit a outputs
- b_out  input  WIDTH  adder p-bit b outputs
- sum_out  input  WIDTH  adder p-bit sum outputs
- busy  output  1  high in SETTLE and ACCUM
- done  output  1  one-cycle pulse; result and ones_cnt are valid
- result  output  WIDTH  decoded word; bit i = 1 iff 2*ones_i > window
- ones_cnt  output  WIDTH*CNT_W  final count for bit i at [i*CNT_W +: CNT_W]

## Operation
- States: IDLE, SETTLE, ACCUM.
- IDLE: when start=1 and window!=0, latch sel and window, clear the working counters, and go to SETTLE (SETTLE_CYC>0) or ACCUM (SETTLE_CYC=0). start with window=0 is ignored. result and ones_cnt hold their last values.
- SETTLE: a settle counter runs SETTLE_CYC cycles. The selected bus is ignored. Then go to ACCUM.
- ACCUM: on every edge, add selected_bus[i] to working counter i and increment the sample counter. On the edge that takes the latched window-th sample:
  - load ones_cnt from the final working counts, including that sample
  - load result[i] = (2*count_i > window), compared at CNT_W+1 bits
  - assert done for one cycle and return to IDLE
- Ties (count = window/2) decode to 0.
- Counters cannot overflow, since count ≤ window ≤ 2^CNT_W−1.
- Latched sel and window are used for the whole measurement. Changes to sel, window or start mid-run have no effect. start while busy is ignored.
- abort=1 in SETTLE or ACCUM returns to IDLE on that edge with no done. result and ones_cnt are unchanged. abort in IDLE is a no-op. abort takes priority over completion on the same edge.
- reset=0 forces IDLE regardless of state, including mid-measurement.

## Timing
- Reset values: busy=0, done=0, result=0, ones_cnt=0, state IDLE, working counters 0.
- start is sampled at edge k, with S = SETTLE_CYC and W = window:
  - busy rises after edge k
  - samples are taken at edges k+S+1 through k+S+W
  - result, ones_cnt and done are updated at edge k+S+W
  - done is high in the cycle between edges k+S+W and k+S+W+1; busy falls at the same edge k+S+W
- Total latency from start edge to done: S+W cycles.
- A new start is accepted during the done cycle, since the block is already in IDLE. back-to-back measurements have no dead cycle.
- Input buses are sampled without registering. Upstream must present them from its own clocked p-bit registers in the same clock domain.

## Test plan
- Stuck sum: reset, SETTLE_CYC=2, sel=0, sum_out=4'b0110 constant, window=100, start → done exactly 102 cycles after start edge; result=4'b0110; ones_cnt bits {3..0} = {0,100,100,0}.
- Tie and majority: sel=0, window=10, sum_out[0] toggles 1,0,1,0… (5 ones), sum_out[1]=1 for 6 of 10 samples → result[0]=0, result[1]=1; ones_cnt[0]=5, ones_cnt[1]=6.
- Bus select latch: start with sel=2, b_out=4'b1001, a_out=4'b0110; change sel to 1 one cycle after start; window=20 → result=4'b1001, all counts 20 or 0.
- Guard cases: start with window=0 → busy stays 0, no done. start pulsed again while busy → ignored, single done at the original time.
- Abort: window=50; abort at sample 30 → busy drops next edge, no done, result keeps its previous value. Abort on the same edge as the final sample → no done.
- Reset mid-run: reset=0 during ACCUM → next cycle all outputs 0 and state IDLE. A subsequent start with window=8, sum_out=4'b1111 → result=4'b1111, counts 8.
